// File: rtl/cdc_handshake_tx_if.sv
// Upstream valid/ready word port of the toggle-handshake CDC transmitter.
// The producer drives the master side; the transmitter takes the slave side.
interface cdc_handshake_tx_if #(
  parameter int WIDTH = 32
);
  logic             Valid;
  logic             Ready;
  logic [WIDTH-1:0] Data;

  modport master (output Valid, output Data, input Ready);
  modport slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle req/ack clock-domain crossing: latches one word,
// flips ReqOut, and holds the word until the resynchronized AckIn matches.
module cdc_handshake_tx #(
  parameter int WIDTH      = 32,
  parameter int SYNCSTAGES = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic               clk,
  input  logic               resetn,
  cdc_handshake_tx_if.slave  src,
  input  logic               ClearErr,
  output logic [WIDTH-1:0]   DataOut,
  output logic               ReqOut,
  input  logic               AckIn,
  output logic               AckErr,
  output logic               TimeoutErr
);

  localparam int SS    = (SYNCSTAGES < 2) ? 2 : SYNCSTAGES;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [SS-1:0] ack_sync_p;
  logic          ack_sync;
  logic          ack_next;
  logic          ack_match;
  logic          ready;
  logic          accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(TIMEOUT)) return v;
    return v + 1'b1;
  endfunction

  // ---- AckIn synchronizer chain; ack_sync is the last stage (AckSync) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ack_sync_p <= '0;
    else         ack_sync_p <= {ack_sync_p[SS-2:0], AckIn};
  end

  assign ack_sync = ack_sync_p[SS-1];
  // Decisions use the value AckSync loads on this edge, so the return to
  // IDLE lands on the same edge that AckSync shows the acknowledge.
  assign ack_next  = ack_sync_p[SS-2];
  assign ack_match = (ack_next == ReqOut);

  // ---- FSM next-state / decode ----
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        ready  = 1'b1;
        accept = src.Valid;
        if (src.Valid) state_d = WAIT;
      end
      WAIT: begin
        if (ack_match) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign src.Ready = ready;

  // ---- state, payload and request toggle registers ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      DataOut <= '0;
      ReqOut  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        DataOut <= src.Data;
        ReqOut  <= ~ReqOut;
      end
    end
  end

  // ---- sticky protocol error; a one-cycle AckIn pulse is caught too ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      AckErr <= 1'b0;
    end else if (ClearErr) begin
      AckErr <= 1'b0;
    end else if (state_q == IDLE && (ack_next != ReqOut || ack_sync != ReqOut)) begin
      AckErr <= 1'b1;
    end
  end

  // ---- optional WAIT watchdog ----
  generate
    if (TIMEOUT > 0) begin : g_wdog
      logic [CNT_W-1:0] wait_cnt;
      logic             terr;
      logic             waiting;

      assign waiting = (state_q == WAIT) && !ack_match;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          wait_cnt <= '0;
          terr     <= 1'b0;
        end else begin
          if (accept)       wait_cnt <= '0;
          else if (waiting) wait_cnt <= sat_inc(wait_cnt);

          // Fires only on the edge that reaches the limit, not while parked there.
          if (ClearErr)
            terr <= 1'b0;
          else if (waiting && wait_cnt == CNT_W'(TIMEOUT - 1))
            terr <= 1'b1;
        end
      end

      assign TimeoutErr = terr;
    end else begin : g_no_wdog
      assign TimeoutErr = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: cycle vector table, scoreboarded
// receiver model, and directed timeout / reset-in-flight sequences.
module tb_cdc_handshake_tx;

  localparam int W  = 32;
  localparam int SS = 2;
  localparam int TO = 8;

  typedef struct packed {
    logic         valid;
    logic [W-1:0] data;
    logic         ack;
    logic         clr;
    logic         e_ready;
    logic         e_req;
    logic [W-1:0] e_dout;
    logic         e_aerr;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         req;
  } sb_t;

  logic         clk       = 1'b0;
  logic         resetn    = 1'b1;
  logic         clear_err = 1'b0;
  logic         man_ack   = 1'b0;
  logic         rx_ack    = 1'b0;
  logic         rx_en     = 1'b0;
  int           rx_dly    = 3;
  logic         ack_in;
  logic [W-1:0] data_out;
  logic         req_out;
  logic         ack_err;
  logic         timeout_err;
  logic         exp_req   = 1'b0;

  int   n_chk  = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  vec_t vt[18];

  cdc_handshake_tx_if #(.WIDTH(W)) bus ();

  assign ack_in = rx_en ? rx_ack : man_ack;

  cdc_handshake_tx #(
    .WIDTH      (W),
    .SYNCSTAGES (SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .src        (bus.slave),
    .ClearErr   (clear_err),
    .DataOut    (data_out),
    .ReqOut     (req_out),
    .AckIn      (ack_in),
    .AckErr     (ack_err),
    .TimeoutErr (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic a,
                              input logic c, input logic er, input logic eq,
                              input logic [W-1:0] ed, input logic ea);
    vec_t t;
    t.valid = v;  t.data = d;  t.ack = a;     t.clr = c;
    t.e_ready = er; t.e_req = eq; t.e_dout = ed; t.e_aerr = ea;
    return t;
  endfunction

  // Offer one word and wait (bounded) for it to be taken.
  task automatic offer(input logic [W-1:0] d, input bit hold, input bit use_sb, input string nm);
    int n;
    @(negedge clk);
    bus.Valid = 1'b1;
    bus.Data  = d;
    n = 0;
    while (!bus.Ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, ".accepted"}, (n < 64), 1'b1);
    exp_req = ~exp_req;
    if (use_sb) sb.push_back('{data: d, req: exp_req});
    @(posedge clk); #1;
    chk1({nm, ".ready_low"}, bus.Ready, 1'b0);
    chk ({nm, ".dout"}, data_out, d);
    chk1({nm, ".req"}, req_out, exp_req);
    bus.Data = ~d;
    if (!hold) bus.Valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.Ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, ".idle"}, bus.Ready, 1'b1);
  endtask

  // Destination-side model: checks the presented word, then toggles its ack.
  initial begin : rx_model
    sb_t e;
    forever begin
      @(negedge clk);
      if (rx_en && resetn && (req_out != rx_ack)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rx.unexpected_req: got req %b with no word outstanding, expected none", req_out);
        end else begin
          e = sb.pop_front();
          chk ("rx.data", data_out, e.data);
          chk1("rx.req",  req_out,  e.req);
        end
        repeat (rx_dly) @(negedge clk);
        rx_ack = ~rx_ack;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.Valid = 1'b0;
    bus.Data  = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 resetn = 1'b0;
    #1;
    chk1("rst.ready", bus.Ready, 1'b1);
    chk1("rst.req",   req_out,   1'b0);
    chk ("rst.dout",  data_out,  '0);
    chk1("rst.aerr",  ack_err,   1'b0);
    chk1("rst.terr",  timeout_err, 1'b0);
    @(negedge clk);
    resetn = 1'b1;

    // Single transfer, then spurious acknowledge and ClearErr priority.
    vt[0]  = mk(1, 32'hDEADBEEF, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    vt[1]  = mk(0, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0);
    vt[2]  = mk(1, 32'h11111111, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    vt[3]  = mk(0, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF, 0);
    vt[4]  = mk(0, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF, 0);
    vt[5]  = mk(0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF, 0);
    vt[6]  = mk(0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF, 0);
    vt[7]  = mk(0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF, 0);
    vt[8]  = mk(0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF, 1);
    vt[9]  = mk(0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF, 1);
    vt[10] = mk(0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF, 1);
    vt[11] = mk(0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF, 0);
    vt[12] = mk(0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF, 0);
    vt[13] = mk(0, 32'h0,        0, 0, 1, 1, 32'hDEADBEEF, 0);
    vt[14] = mk(0, 32'h0,        0, 1, 1, 1, 32'hDEADBEEF, 0);
    vt[15] = mk(0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF, 0);
    vt[16] = mk(0, 32'h0,        1, 1, 1, 1, 32'hDEADBEEF, 0);
    vt[17] = mk(0, 32'h0,        1, 0, 1, 1, 32'hDEADBEEF, 0);

    for (int i = 0; i < 18; i++) begin
      bus.Valid = vt[i].valid;
      bus.Data  = vt[i].data;
      man_ack   = vt[i].ack;
      clear_err = vt[i].clr;
      @(posedge clk); #1;
      chk1($sformatf("vec%0d.ready", i), bus.Ready,   vt[i].e_ready);
      chk1($sformatf("vec%0d.req",   i), req_out,     vt[i].e_req);
      chk ($sformatf("vec%0d.dout",  i), data_out,    vt[i].e_dout);
      chk1($sformatf("vec%0d.aerr",  i), ack_err,     vt[i].e_aerr);
      chk1($sformatf("vec%0d.terr",  i), timeout_err, 1'b0);
      @(negedge clk);
    end
    bus.Valid = 1'b0;
    clear_err = 1'b0;

    // Hold-off: Valid held high across three scoreboarded transfers.
    resetn  = 1'b0;
    man_ack = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    exp_req = 1'b0;
    rx_ack  = 1'b0;
    rx_en   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      offer(W'(k), 1'b1, 1'b1, $sformatf("hold%0d", k));
      repeat (2) @(negedge clk);
    end
    bus.Valid = 1'b0;
    wait_idle("hold.end");
    chk("hold.sb_empty", W'(sb.size()), '0);
    chk1("hold.aerr", ack_err, 1'b0);
    chk1("hold.terr", timeout_err, 1'b0);
    man_ack = rx_ack;
    rx_en   = 1'b0;

    // Watchdog: never acknowledge, then a late acknowledge.
    offer(32'hCAFE0001, 1'b0, 1'b0, "to");
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("to.terr_w%0d", i),  timeout_err, (i >= TO));
      chk1($sformatf("to.ready_w%0d", i), bus.Ready,   1'b0);
    end
    chk("to.dout_held", data_out, 32'hCAFE0001);
    @(negedge clk);
    man_ack = exp_req;
    @(posedge clk); #1;
    chk1("to.ready_first_sample", bus.Ready, 1'b0);
    @(posedge clk); #1;
    chk1("to.ready_back", bus.Ready, 1'b1);
    chk1("to.terr_sticky", timeout_err, 1'b1);
    chk1("to.aerr", ack_err, 1'b0);
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk1("to.terr_cleared", timeout_err, 1'b0);

    // Reset while a word is in flight, then a clean fresh transfer.
    offer(32'h12345678, 1'b0, 1'b0, "rw");
    #2;
    resetn = 1'b0;
    #1;
    chk1("rw.ready", bus.Ready, 1'b1);
    chk1("rw.req",   req_out,   1'b0);
    chk ("rw.dout",  data_out,  '0);
    chk1("rw.terr",  timeout_err, 1'b0);
    man_ack = 1'b0;
    exp_req = 1'b0;
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    rx_ack = 1'b0;
    rx_en  = 1'b1;
    offer(32'h5A5A5A5A, 1'b0, 1'b1, "fresh");
    wait_idle("fresh.end");
    repeat (4) @(negedge clk);
    chk ("fresh.dout", data_out, 32'h5A5A5A5A);
    chk1("fresh.aerr", ack_err, 1'b0);
    chk ("fresh.sb_empty", W'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain side of a toggle-based request/acknowledge clock-domain crossing that carries a WIDTH-bit word to a destination domain. It accepts one word per transfer through a valid/ready port and holds it stable on DataOut. It signals the word with a toggle on ReqOut and waits for the destination's toggle acknowledge, which it re-synchronizes internally through a SYNCSTAGES-deep flop chain. It sits at the boundary of any source-domain unit (CSR, debug, peripheral) that pushes data into an asynchronous domain whose receiver synchronizes ReqOut.

## Interface
- WIDTH, 32, payload width in bits
- SYNCSTAGES, 2, flops in the AckIn synchronizer chain; minimum 2
- TIMEOUT, 0, WAIT cycles before TimeoutErr sets; 0 disables the watchdog
- clk  in  1  source-domain clock, rising edge
- resetn  in  1  reset; one clock, asynchronous assertion, active-low
- Valid  in  1  Data is offered this cycle
- Ready  out  1  block can accept a word this cycle
- Data  in  WIDTH  word to transfer
- ClearErr  in  1  synchronous clear of both sticky error flags
- DataOut  out  WIDTH  registered payload to the destination domain; stable whenever ReqOut and the acknowledge differ
- ReqOut  out  1  request toggle; registered, glitch-free
- AckIn  in  1  acknowledge toggle from the destination domain; asynchronous to clk
- AckErr  out  1  sticky: acknowledge toggled while no request was outstanding
- TimeoutErr  out  1  sticky: WAIT lasted TIMEOUT cycles

## Operation
- AckSync is the last stage of a SYNCSTAGES-flop chain on AckIn. All chain flops reset to 0.
- FSM states:
  - IDLE: Ready=1. On Valid&Ready at an edge: DataOut<=Data, ReqOut<=~ReqOut, WaitCnt<=0, go to WAIT.
  - WAIT: Ready=0; Valid and Data are ignored. While AckSync!=ReqOut, WaitCnt increments and saturates at TIMEOUT. When AckSync==ReqOut, go to IDLE on that edge.
- Ready is a pure decode of state (IDLE) and has no combinational path from Valid or AckIn.
- DataOut and ReqOut change only on an accept edge. DataOut is never modified during WAIT.
- AckErr: set on any edge in IDLE where AckSync!=ReqOut. It stays set until ClearErr. It does not block Ready.
- TimeoutErr:
  - If TIMEOUT>0, it sets on the edge where WaitCnt reaches TIMEOUT while still in WAIT.
  - The FSM stays in WAIT with no retry and no abort.
  - It stays set until ClearErr.
- ClearErr takes priority over a simultaneous set.
- WaitCnt width is $clog2(TIMEOUT+1). When TIMEOUT=0 the counter is absent and TimeoutErr is tied to 0.

## Timing
- Reset values (asynchronous, resetn=0): state=IDLE, Ready=1, ReqOut=0, DataOut=0, AckSync chain=0, AckErr=0, TimeoutErr=0, WaitCnt=0.
- Accept at edge N: ReqOut and DataOut are updated after edge N. Ready=0 from edge N until the return edge.
- Acknowledge path: AckIn changes and is first sampled at edge M. AckSync reflects it after edge M+SYNCSTAGES-1. The FSM returns to IDLE at edge M+SYNCSTAGES-1, and Ready=1 after that edge.
- Minimum source-side turnaround is 1 (accept) + destination latency + SYNCSTAGES cycles.
- Throughput: at most one word per complete four-phase-free toggle round trip. Back-to-back Valid is held off by Ready.
- Reset mid-transfer: the block returns to IDLE with ReqOut=0 and drops the pending word. The destination side must be reset in the same event; otherwise the toggle phase mismatch is reported as AckErr.
- The AckIn/AckSync boundary is the only asynchronous input. No other input is synchronized.

## Test plan
- Reset: drive resetn=0 mid-cycle -> all outputs take their reset values immediately without a clock edge; Ready=1, ReqOut=0, DataOut=0.
- Single transfer (SYNCSTAGES=2): Valid=1, Data=32'hDEADBEEF at edge 1 -> after edge 1 ReqOut=1, DataOut=DEADBEEF, Ready=0. Model acknowledge toggles AckIn=1 sampled at edge 5 -> Ready=1 after edge 6; DataOut still DEADBEEF.
- Hold-off: Valid held high with Data incrementing 1,2,3 across three transfers -> DataOut takes exactly 1, 2, 3. ReqOut toggles 1,0,1. No word is taken while Ready=0.
- Spurious acknowledge: in IDLE toggle AckIn -> AckErr=1 two edges later and stays set. Pulse ClearErr with AckIn restored -> AckErr=0. Assert ClearErr on a set edge -> AckErr stays 0.
- Timeout (TIMEOUT=8): accept a word and never acknowledge -> TimeoutErr=1 after WAIT cycle 8, Ready stays 0. A late acknowledge then returns the FSM to IDLE, and TimeoutErr stays set until ClearErr.
- Reset during WAIT: accept a word, assert resetn=0 before the acknowledge -> IDLE, ReqOut=0, DataOut=0. Then reset the model receiver and complete a fresh transfer of 32'h5A5A5A5A with no AckErr.
